// File: rtl/attn_pkg.sv
// attn_pkg: types shared between the token precision scanner and the A*V
// multiply stage.
//   prec_t  : per-token precision code (INT4 / INT8 / FP16), 4 bits wide.
//   state_t : state encoding of the attention_token_precision FSM.
package attn_pkg;

  typedef enum logic [3:0] {
    PREC_INT4 = 4'd0,
    PREC_INT8 = 4'd1,
    PREC_FP16 = 4'd2
  } prec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_CLASS,
    S_DONE
  } state_t;

endpackage

// File: rtl/token_prec_classifier.sv
// token_prec_classifier: combinational precision decision for one key token.
//   sum    in  ACC_W  column sum of attention weights for the token
//   thr_hi in  ACC_W  sum >= thr_hi selects FP16
//   thr_lo in  ACC_W  otherwise sum >= thr_lo selects INT8, else INT4
//   prec   out prec_t selected code
// thr_hi is tested first, so thr_lo > thr_hi can never produce INT8.
module token_prec_classifier
  import attn_pkg::*;
#(
  parameter int ACC_W = 19
) (
  input  logic [ACC_W-1:0] sum,
  input  logic [ACC_W-1:0] thr_hi,
  input  logic [ACC_W-1:0] thr_lo,
  output prec_t            prec
);

  always_comb begin
    prec = PREC_INT4;
    if (sum >= thr_hi) begin
      prec = PREC_FP16;
    end else if (sum >= thr_lo) begin
      prec = PREC_INT8;
    end
  end

endmodule

// File: rtl/attention_token_precision.sv
// attention_token_precision: scans the softmax attention matrix once, sums
// each key-token column over all (row, head) pairs and assigns each token a
// precision code for the downstream A*V stage.
//   clk, rst_n       clock, asynchronous active-low reset
//   start            begin a pass (only honoured in S_IDLE)
//   A_in             A[l][n][l2] at ((l*N*L)+(n*L)+l2)*DATA_WIDTH, captured in S_LOAD
//   thr_hi, thr_lo   FP16 / INT8 thresholds, captured with A_in
//   token_precision  per-token code, updated only in S_CLASS
//   done             one-cycle completion pulse
//   out_valid        token_precision valid, cleared when a new start is accepted
// Optional feature macro TOKEN_PREC_STATS_EN adds cnt_int4/cnt_int8/cnt_fp16,
// the number of tokens assigned each code, registered in S_CLASS.
module attention_token_precision
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  localparam int ACC_W     = DATA_WIDTH + $clog2(L*N)
`ifdef TOKEN_PREC_STATS_EN
  ,
  localparam int CNT_W     = $clog2(L+1)
`endif
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [DATA_WIDTH*L*N*L-1:0]    A_in,
  input  logic [ACC_W-1:0]               thr_hi,
  input  logic [ACC_W-1:0]               thr_lo,
  output logic [L-1:0][3:0]              token_precision,
  output logic                           done,
  output logic                           out_valid
`ifdef TOKEN_PREC_STATS_EN
  ,
  output logic [CNT_W-1:0]               cnt_int4,
  output logic [CNT_W-1:0]               cnt_int8,
  output logic [CNT_W-1:0]               cnt_fp16
`endif
);

  localparam int ROWS  = L * N;
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t state, state_nxt;

  // Row r = l*N+n is the r-th group of L elements in A_in, so a packed
  // [row][column] view matches the flat layout directly.
  logic [ROWS-1:0][L-1:0][DATA_WIDTH-1:0] a_q;
  logic [ACC_W-1:0]                       thr_hi_q, thr_lo_q;
  logic [ROW_W-1:0]                       row_q;
  logic [L-1:0][ACC_W-1:0]                sum_q;
  prec_t                                  code [L];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ACC;
      S_ACC:   if (row_q == LAST_ROW) state_nxt = S_CLASS;
      S_CLASS: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q             <= '0;
      thr_hi_q        <= '0;
      thr_lo_q        <= '0;
      row_q           <= '0;
      sum_q           <= '0;
      token_precision <= '0;
      done            <= 1'b0;
      out_valid       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) out_valid <= 1'b0;
        end
        S_LOAD: begin
          a_q      <= A_in;
          thr_hi_q <= thr_hi;
          thr_lo_q <= thr_lo;
          sum_q    <= '0;
          row_q    <= '0;
        end
        S_ACC: begin
          for (int unsigned c = 0; c < L; c++) begin
            sum_q[c] <= sum_q[c] + ACC_W'(a_q[row_q][c]);
          end
          row_q <= (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
        end
        S_CLASS: begin
          for (int unsigned c = 0; c < L; c++) begin
            token_precision[c] <= code[c];
          end
        end
        S_DONE: begin
          done      <= 1'b1;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_cls
    token_prec_classifier #(
      .ACC_W (ACC_W)
    ) u_cls (
      .sum    (sum_q[g]),
      .thr_hi (thr_hi_q),
      .thr_lo (thr_lo_q),
      .prec   (code[g])
    );
  end

`ifdef TOKEN_PREC_STATS_EN
  logic [CNT_W-1:0] n_int4, n_int8, n_fp16;

  always_comb begin
    n_int4 = '0;
    n_int8 = '0;
    n_fp16 = '0;
    for (int unsigned c = 0; c < L; c++) begin
      unique case (code[c])
        PREC_INT8: n_int8 = n_int8 + CNT_W'(1);
        PREC_FP16: n_fp16 = n_fp16 + CNT_W'(1);
        default:   n_int4 = n_int4 + CNT_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_int4 <= '0;
      cnt_int8 <= '0;
      cnt_fp16 <= '0;
    end else if (state == S_CLASS) begin
      cnt_int4 <= n_int4;
      cnt_int8 <= n_int8;
      cnt_fp16 <= n_fp16;
    end
  end
`endif

endmodule

// File: tb/tb_attention_token_precision.sv
module tb_attention_token_precision;

  localparam int DW    = 16;
  localparam int L     = 8;
  localparam int N     = 1;
  localparam int ROWS  = L * N;
  localparam int ACC_W = 19;
`ifdef TOKEN_PREC_STATS_EN
  localparam int CNT_W = 4;
`endif

  typedef struct packed {
    logic [L-1:0][3:0] codes;
    logic [7:0]        n4;
    logic [7:0]        n8;
    logic [7:0]        n16;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          start = 1'b0;
  logic [ROWS-1:0][L-1:0][DW-1:0] a_vec = '0;
  logic [ACC_W-1:0]              thr_hi = '0;
  logic [ACC_W-1:0]              thr_lo = '0;
  logic [L-1:0][3:0]             token_precision;
  logic                          done;
  logic                          out_valid;
`ifdef TOKEN_PREC_STATS_EN
  logic [CNT_W-1:0]              cnt_int4, cnt_int8, cnt_fp16;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  attention_token_precision #(
    .DATA_WIDTH (DW),
    .L          (L),
    .N          (N)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .A_in            (a_vec),
    .thr_hi          (thr_hi),
    .thr_lo          (thr_lo),
    .token_precision (token_precision),
    .done            (done),
    .out_valid       (out_valid)
`ifdef TOKEN_PREC_STATS_EN
    ,
    .cnt_int4        (cnt_int4),
    .cnt_int8        (cnt_int8),
    .cnt_fp16        (cnt_fp16)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [ACC_W-1:0] hi, input logic [ACC_W-1:0] lo);
    exp_t e;
    longint s;
    e = '0;
    for (int c = 0; c < L; c++) begin
      s = 0;
      for (int r = 0; r < ROWS; r++) s += longint'(a_vec[r][c]);
      if (s >= longint'(hi)) begin
        e.codes[c] = 4'd2; e.n16++;
      end else if (s >= longint'(lo)) begin
        e.codes[c] = 4'd1; e.n8++;
      end else begin
        e.codes[c] = 4'd0; e.n4++;
      end
    end
    return e;
  endfunction

  task automatic fill_all(input logic [DW-1:0] v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < L; c++) a_vec[r][c] = v;
  endtask

  task automatic scramble();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < L; c++) a_vec[r][c] = DW'($urandom);
    thr_hi = ACC_W'($urandom);
    thr_lo = ACC_W'($urandom);
  endtask

  // Drives one pass; expected codes enter the scoreboard at start and are
  // popped when done is seen.
  task automatic run_pass(input string name, input logic [ACC_W-1:0] hi,
                          input logic [ACC_W-1:0] lo, input bit mid_start);
    exp_t e;
    int   n;
    int   extra;
    bit   got;
    @(negedge clk);
    thr_hi = hi;
    thr_lo = lo;
    sb.push_back(model(hi, lo));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({name, "_ov_clear"}, 32'(out_valid), 32'd0);
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      #1 n++;
      if (n == 1) scramble();
      if (mid_start && n == 4) start = 1'b1;
      if (mid_start && n == 5) start = 1'b0;
      if (done) got = 1'b1;
    end
    check({name, "_latency"}, 32'(n), 32'd11);
    e = sb.pop_front();
    for (int c = 0; c < L; c++)
      check($sformatf("%s_tok%0d", name, c), 32'(token_precision[c]), 32'(e.codes[c]));
    check({name, "_ov"}, 32'(out_valid), 32'd1);
`ifdef TOKEN_PREC_STATS_EN
    check({name, "_cnt4"}, 32'(cnt_int4), 32'(e.n4));
    check({name, "_cnt8"}, 32'(cnt_int8), 32'(e.n8));
    check({name, "_cnt16"}, 32'(cnt_fp16), 32'(e.n16));
`endif
    @(posedge clk);
    #1 check({name, "_done_width"}, 32'(done), 32'd0);
    check({name, "_ov_hold"}, 32'(out_valid), 32'd1);
    if (mid_start) begin
      extra = 0;
      repeat (15) begin
        @(posedge clk);
        #1 if (done) extra++;
      end
      check({name, "_single_done"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_tok", 32'(token_precision), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // uniform 0x1000 -> every column sum 0x8000
    fill_all(16'h1000);
    run_pass("t1_fp16", 19'h08000, 19'h00000, 1'b0);
    fill_all(16'h1000);
    run_pass("t2_int8", 19'h08001, 19'h08000, 1'b0);
    fill_all(16'h1000);
    run_pass("t2_int4", 19'h08001, 19'h08001, 1'b0);

    // single hot column 3
    fill_all(16'h0000);
    for (int r = 0; r < ROWS; r++) a_vec[r][3] = 16'h8000;
    run_pass("t3_col3", 19'h10000, 19'h00001, 1'b0);

    // maximum sum, no wrap
    fill_all(16'hFFFF);
    run_pass("t4_max", 19'h7FFF8, 19'h00000, 1'b0);

    // start pulsed during accumulation
    fill_all(16'h1000);
    run_pass("t5_midstart", 19'h08000, 19'h00000, 1'b0);
    fill_all(16'h1000);
    run_pass("t5_ignored", 19'h08001, 19'h08000, 1'b1);

    // reset during accumulation
    fill_all(16'h1000);
    @(negedge clk);
    thr_hi = 19'h08000;
    thr_lo = 19'h0;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_ov", 32'(out_valid), 32'd0);
    check("t5_rst_tok", 32'(token_precision), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    fill_all(16'h1000);
    run_pass("t5_after_rst", 19'h08000, 19'h00000, 1'b0);

    // inverted thresholds, mixed sums 0x8000 / 0x7000
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < L; c++) a_vec[r][c] = (c % 2 == 0) ? 16'h1000 : 16'h0E00;
    run_pass("t6_inv", 19'h08000, 19'h09000, 1'b0);

    // random contents
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < L; c++) a_vec[r][c] = DW'($urandom);
      run_pass($sformatf("rnd%0d", k), ACC_W'($urandom_range(19'h50000, 19'h38000)),
               ACC_W'($urandom_range(19'h37FFF, 19'h20000)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
